// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: bundle of the four input streams and the tagged output stream.
//   i0..i3 / i0_valid..i3_valid / i0_ready..i3_ready : source channels
//   y / sel / y_valid / y_ready                      : merged output stream
// master: the side that drives sources and consumes y (testbench / upstream+downstream).
// slave : the arbiter itself.
interface mux4_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i0_valid;
    logic             i1_valid;
    logic             i2_valid;
    logic             i3_valid;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic             i0_ready;
    logic             i1_ready;
    logic             i2_ready;
    logic             i3_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y;
    logic [1:0]       sel;
    logic             y_ready;

    modport master (
        output i0_valid, i1_valid, i2_valid, i3_valid,
        output i0, i1, i2, i3,
        output y_ready,
        input  i0_ready, i1_ready, i2_ready, i3_ready,
        input  y_valid, y, sel
    );

    modport slave (
        input  i0_valid, i1_valid, i2_valid, i3_valid,
        input  i0, i1, i2, i3,
        input  y_ready,
        output i0_ready, i1_ready, i2_ready, i3_ready,
        output y_valid, y, sel
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: merges four valid/ready streams into one registered output
// tagged with the 2-bit source channel index (sel).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux4_rr_arbiter_if.slave (inputs i0..i3 with valid/ready, output y/sel/y_valid/y_ready)
// Build option: define MUX4_RR_EN for round-robin arbitration; otherwise fixed
// priority with channel 0 highest.
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux4_rr_arbiter_if.slave      bus
);
    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   y_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;

    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    ready_c;
    logic [WIDTH-1:0]   din [N_CH];
    logic               load;
    logic               found;
    logic [SEL_W-1:0]   gnt;

`ifdef MUX4_RR_EN
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   ptr_d;
    logic [SEL_W-1:0]   cand;
`endif

    // Gather channel requests and data into indexable form.
    always_comb begin
        req     = {bus.i3_valid, bus.i2_valid, bus.i1_valid, bus.i0_valid};
        din[0]  = bus.i0;
        din[1]  = bus.i1;
        din[2]  = bus.i2;
        din[3]  = bus.i3;
    end

    // Grant selection.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
`ifdef MUX4_RR_EN
        cand  = '0;
        // Search upward from the channel after the last winner, wrapping mod 4.
        for (int k = 0; k < int'(N_CH); k++) begin
            cand = ptr_q + SEL_W'(k + 1);
            if (!found && req[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
`else
        // Descending scan so the lowest-index requester is the last to overwrite.
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if (req[k]) begin
                found = 1'b1;
                gnt   = SEL_W'(k);
            end
        end
`endif
    end

    // Next-state, register loads and combinational readys.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        sel_d   = sel_q;
        ready_c = '0;
`ifdef MUX4_RR_EN
        ptr_d   = ptr_q;
`endif
        // Register can accept when empty or being drained this edge.
        load = (state_q == EMPTY) || bus.y_ready;

        // No handshake may complete on a reset edge.
        if (rst_n && load) begin
            if (found) begin
                ready_c[gnt] = 1'b1;
                state_d      = FULL;
                y_d          = din[gnt];
                sel_d        = gnt;
`ifdef MUX4_RR_EN
                ptr_d        = gnt;
`endif
            end else begin
                state_d = EMPTY;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            y_q     <= '0;
            sel_q   <= '0;
`ifdef MUX4_RR_EN
            ptr_q   <= 2'b11;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
`ifdef MUX4_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.y_valid  = (state_q == FULL);
    assign bus.y        = y_q;
    assign bus.sel      = sel_q;
    assign bus.i0_ready = ready_c[0];
    assign bus.i1_ready = ready_c[1];
    assign bus.i2_ready = ready_c[2];
    assign bus.i3_ready = ready_c[3];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed stimulus with a queue-based scoreboard; a
// negedge monitor pops an expected {sel, y} for every output transfer.
module tb_mux4_rr_arbiter;
    localparam int unsigned WIDTH = 8;
`ifdef MUX4_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]       sel;
        logic [WIDTH-1:0] y;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] rdy();
        return {bus.i3_ready, bus.i2_ready, bus.i1_ready, bus.i0_ready};
    endfunction

    task automatic set_in(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        bus.i0_valid = v[0];
        bus.i1_valid = v[1];
        bus.i2_valid = v[2];
        bus.i3_valid = v[3];
        bus.i0 = d0;
        bus.i1 = d1;
        bus.i2 = d2;
        bus.i3 = d3;
    endtask

    task automatic push(input int s, input int d);
        exp_t e;
        e.sel = 2'(s);
        e.y   = WIDTH'(d);
        exp_q.push_back(e);
    endtask

    // One clock, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a transfer completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && bus.y_valid && bus.y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output sel=%0d y=%0h", bus.sel, bus.y);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_sel", 32'(bus.sel), 32'(e.sel));
                check("out_y", 32'(bus.y), 32'(e.y));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;

        // Reset with all valids high.
        rst_n = 1'b0;
        bus.y_ready = 1'b1;
        set_in(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
        #1;
        check("rst_ready", 32'(rdy()), 32'h0);
        step();
        step();
        check("rst_y_valid", 32'(bus.y_valid), 32'h0);
        check("rst_y", 32'(bus.y), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_ready2", 32'(rdy()), 32'h0);

        // Release with no requests.
        set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        step();
        check("idle_y_valid", 32'(bus.y_valid), 32'h0);
        check("idle_ready", 32'(rdy()), 32'h0);

        // Single channel 2.
        set_in(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
        #1;
        check("single_ready", 32'(rdy()), 32'b0100);
        push(2, 8'hA5);
        step();
        check("single_y_valid", 32'(bus.y_valid), 32'h1);
        check("single_y", 32'(bus.y), 32'hA5);
        check("single_sel", 32'(bus.sel), 32'h2);
        set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        check("single_drain", 32'(bus.y_valid), 32'h0);

        // Fresh pointer, then all four valid for 8 transfers.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_in(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        for (int k = 0; k < 8; k++) begin
            int g;
            g = RR ? (k % 4) : 0;
            #1;
            check("fair_ready", 32'(rdy()), 32'(4'b0001 << g));
            push(g, 8'h10 + g);
            step();
            check("fair_sel", 32'(bus.sel), 32'(g));
        end
        set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        check("fair_drain", 32'(bus.y_valid), 32'h0);

        // Backpressure: hold y=11/sel=1 while channel 2 waits.
        set_in(4'b0010, 8'h00, 8'h11, 8'h00, 8'h00);
        #1;
        check("bp_load_ready", 32'(rdy()), 32'b0010);
        push(1, 8'h11);
        step();
        bus.y_ready = 1'b0;
        set_in(4'b0100, 8'h00, 8'h00, 8'h22, 8'h00);
        #1;
        check("bp_ready_blocked", 32'(rdy()), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_y_valid", 32'(bus.y_valid), 32'h1);
            check("bp_y", 32'(bus.y), 32'h11);
            check("bp_sel", 32'(bus.sel), 32'h1);
            check("bp_ready", 32'(rdy()), 32'h0);
        end
        bus.y_ready = 1'b1;
        #1;
        check("bp_drain_load_ready", 32'(rdy()), 32'b0100);
        push(2, 8'h22);
        step();
        check("bp_after_valid", 32'(bus.y_valid), 32'h1);
        check("bp_after_y", 32'(bus.y), 32'h22);
        check("bp_after_sel", 32'(bus.sel), 32'h2);
        set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        check("bp_empty", 32'(bus.y_valid), 32'h0);

        // Mid-stream reset: word held with i0 still valid is discarded.
        bus.y_ready = 1'b0;
        set_in(4'b0001, 8'h30, 8'h00, 8'h00, 8'h00);
        step();
        check("mr_full", 32'(bus.y_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_ready_in_reset", 32'(rdy()), 32'h0);
        step();
        check("mr_y_valid", 32'(bus.y_valid), 32'h0);
        check("mr_y", 32'(bus.y), 32'h0);
        rst_n = 1'b1;
        bus.y_ready = 1'b1;
        set_in(4'b1111, 8'h40, 8'h41, 8'h42, 8'h43);
        #1;
        check("mr_first_grant", 32'(rdy()), 32'b0001);
        push(0, 8'h40);
        step();
        set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step();

        // Pointer hold across idle cycles.
        set_in(4'b0010, 8'h00, 8'h51, 8'h00, 8'h00);
        #1;
        check("ph_grant1", 32'(rdy()), 32'b0010);
        push(1, 8'h51);
        step();
        set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) step();
        check("ph_idle", 32'(bus.y_valid), 32'h0);
        set_in(4'b0101, 8'h60, 8'h00, 8'h62, 8'h00);
        #1;
        check("ph_ready", 32'(rdy()), RR ? 32'b0100 : 32'b0001);
        if (RR) push(2, 8'h62); else push(0, 8'h60);
        step();
        #1;
        check("ph_ready2", 32'(rdy()), 32'b0001);
        push(0, 8'h60);
        step();
        set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Merges four independent valid/ready input streams into one output stream.
- Counterpart of the team's 1-to-4 demultiplexer: the demux fans one source out to y0..y3; this block funnels four sources back to one.
- Output is registered and tagged with a 2-bit `sel` giving the source channel, so a downstream demux can route on it directly.
- Arbitration is round-robin by default; fixed priority is selectable at compile time.

## Interface
- `WIDTH`, default 8: data width of every channel.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `i0_valid`..`i3_valid`  input  1 each  channel n has data.
- `i0`..`i3`  input  WIDTH each  channel n data.
- `i0_ready`..`i3_ready`  output  1 each  channel n transfer accepted this cycle.
- `y_valid`  output  1  output register holds data.
- `y`  output  WIDTH  output data.
- `sel`  output  2  source channel index of `y`.
- `y_ready`  input  1  downstream accepts `y`.

## Operation
- Transfer on channel n when `in_valid` and `in_ready` are both high at a rising edge. The output transfers when `y_valid` and `y_ready` are both high.
- Output register state is `EMPTY` (`y_valid`=0) or `FULL` (`y_valid`=1).
- `load` = `!y_valid || y_ready`. The register can take a new word this cycle.
- Grant `g` is picked among channels with valid high. The search starts at `ptr+1` (mod 4) and wraps upward.
- `in_ready[g]` = `load` and a request is present. All other readys are 0.
  - At most one `in_ready` is high in any cycle.
  - Readys are combinational from the valids, `y_ready` and state. No valid depends on a ready.
- On a load with a grant:
  - `y` <= `i[g]`, `sel` <= `g`, `y_valid` <= 1.
  - `ptr` <= `g`.
- On a load with no request: `y_valid` <= 0. `y`, `sel` and `ptr` hold.
- While `FULL` and `y_ready`=0: `y`, `sel` and `y_valid` hold stable, and all `in_ready`=0.
- `ptr` (2 bits) updates only on an accepted input transfer. It never changes on idle cycles.
- Simultaneous drain and load: the output transfer and the new input transfer both occur on the same edge. `y_valid` stays 1.
- Reset mid-operation: the held word is discarded and no handshake completes that edge. Inputs are not acknowledged during a reset cycle (`in_ready` forced 0 while `rst_n`=0).

## Timing
- Reset values:
  - `y_valid`=0, `y`=0, `sel`=2'b00.
  - `ptr`=2'b11, so channel 0 is first in line.
  - All `in_ready`=0 while `rst_n` is low.
- Latency: a word accepted at edge N is on `y`/`sel` with `y_valid`=1 from edge N until consumed. This is one register stage.
- Throughput: one word per cycle while `y_ready` is held high and any input is valid.
- Fairness (RR): with all four valid continuously and `y_ready`=1, grants cycle 0,1,2,3,0,... A channel that stays valid waits at most 3 transfers.
- `y`/`sel` never change while `y_valid`=1 and `y_ready`=0.

## Configuration
- `MUX4_RR_EN` defined: round-robin arbitration with `ptr` as described.
- `MUX4_RR_EN` undefined: fixed priority, where the lowest-index valid channel always wins (0 > 1 > 2 > 3).
  - `ptr` is not implemented.
  - All handshake, latency and reset behaviour is unchanged.

## Test plan
- Reset then idle:
  - Hold `rst_n`=0 for 2 cycles with all valids high → `y_valid`=0, `y`=0, `sel`=0, every `in_ready`=0.
  - Release with all valids low → `y_valid` stays 0.
- Single channel:
  - Drive `i2_valid`=1, `i2`=8'hA5, `y_ready`=1 → `i2_ready`=1. Next cycle `y`=8'hA5, `sel`=2'b10, `y_valid`=1.
  - Drop `i2_valid` → `y_valid`=0 one cycle later.
- RR fairness:
  - Setup: all four valid, data 8'h10/8'h11/8'h12/8'h13, `y_ready`=1 for 8 cycles.
  - Expected `sel`: 0,1,2,3,0,1,2,3 with matching data.
  - With `MUX4_RR_EN` undefined, `sel`=0 for all 8.
- Backpressure:
  - Setup: output FULL with `y`=8'h11, `sel`=1; set `y_ready`=0 for 3 cycles.
  - Expected: `y`/`sel` stable and all `in_ready`=0.
  - Raise `y_ready` → drain and load of channel 2 on the same edge.
- Mid-stream reset: pull `rst_n` low while `y_valid`=1 and `i0_valid`=1 → next edge `y_valid`=0, no `i0_ready`. After release, channel 0 is granted first.
- Pointer hold:
  - Grant channel 1, then idle 5 cycles.
  - Then assert `i0_valid` and `i2_valid` → channel 2 granted first (RR build).
